// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the two-port async_mem arbiter: FSM encoding, port
// indices and the default read wait-state count.
package mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t DONE   = 2'd2;

  localparam int unsigned PORT_CPU = 0;
  localparam int unsigned PORT_DMA = 1;

  localparam int unsigned DEF_WAIT_CYCLES = 3;

  // One-hot grant vector for a port index.
  function automatic logic [1:0] port_mask(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signal bundle of mem_port_arbiter.
// The arbiter uses the slave modport; requesters and memory use master.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ready;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ready;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  logic [1:0]        grant;
  logic              busy;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_read_data,
    input  p0_ready, p0_rdata, p1_ready, p1_rdata,
    input  mem_read, mem_write, mem_addr, mem_write_data,
    input  grant, busy
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_read_data,
    output p0_ready, p0_rdata, p1_ready, p1_rdata,
    output mem_read, mem_write, mem_addr, mem_write_data,
    output grant, busy
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = req;
    if (req == 2'b11) grant_c = port_mask(~last_grant);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port async_mem between two requesters with round-robin
// arbitration, WAIT_CYCLES read wait states and one-clock write strobes.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [1:0]        grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              ready0_q, ready0_d;
  logic              ready1_q, ready1_d;
  logic [1:0]        pick_c;

  rr_arb2 u_rr_arb2 (
    .req        ({bus.p1_req, bus.p0_req}),
    .last_grant (last_q),
    .grant_c    (pick_c)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    grant_d  = grant_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    ready0_d = 1'b0;
    ready1_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_c != 2'b00) begin
          state_d = ACCESS;
          cnt_d   = '0;
          last_d  = pick_c[PORT_DMA];
          grant_d = pick_c;
          if (pick_c[PORT_DMA]) begin
            we_d    = bus.p1_we;
            addr_d  = bus.p1_addr;
            wdata_d = bus.p1_wdata;
          end else begin
            we_d    = bus.p0_we;
            addr_d  = bus.p0_addr;
            wdata_d = bus.p0_wdata;
          end
          rd_d = ~we_d;
          wr_d = we_d;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d  = DONE;
          ready0_d = grant_q[PORT_CPU];
          ready1_d = grant_q[PORT_DMA];
        end else if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
          state_d  = DONE;
          rdata_d  = bus.mem_read_data;
          ready0_d = grant_q[PORT_CPU];
          ready1_d = grant_q[PORT_DMA];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          rd_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'(PORT_DMA);
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      grant_q  <= 2'b00;
      busy_q   <= 1'b0;
      ready0_q <= 1'b0;
      ready1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      ready0_q <= ready0_d;
      ready1_q <= ready1_d;
    end
  end

  assign bus.mem_read       = rd_q;
  assign bus.mem_write      = wr_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.grant          = grant_q;
  assign bus.busy           = busy_q;
  assign bus.p0_ready       = ready0_q;
  assign bus.p1_ready       = ready1_q;
  assign bus.p0_rdata       = rdata_q;
  assign bus.p1_rdata       = rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port `async_mem` (combinational read, posedge-write) between two requesters.
- Port 0 is the `multi_cycle_mips` memory interface; port 1 is a DMA/loader or debug master.
- Round-robin arbitration between the two ports.
- Read accesses are sequenced with a programmable number of wait states to cover the memory's asynchronous read delay.
- Write strobes last exactly one clock.

Parameters:
- WAIT_CYCLES, 3, clock cycles `mem_read` is held before read data is captured; must be ≥1. 3 covers a 7 ns read at a 2.5 ns clock.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- p0_req  input  1  port 0 access request; held until p0_ready.
- p0_we  input  1  port 0 write enable (1 = write, 0 = read).
- p0_addr  input  ADDR_W  port 0 byte address.
- p0_wdata  input  DATA_W  port 0 write data.
- p0_ready  output  1  one-cycle completion pulse for port 0.
- p0_rdata  output  DATA_W  read data for port 0; valid while p0_ready is high.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ready, p1_rdata: same as port 0, for port 1.
- mem_read  output  1  to async_mem read.
- mem_write  output  1  to async_mem write.
- mem_addr  output  ADDR_W  to async_mem address.
- mem_write_data  output  DATA_W  to async_mem write_data.
- mem_read_data  input  DATA_W  from async_mem read_data.
- grant  output  2  one-hot owner of the current access; 00 when idle.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - All outputs 0: grant=00, busy=0, mem_read=0, mem_write=0, mem_addr=0, mem_write_data=0, px_ready=0, px_rdata=0.
  - last_grant = port 1, so port 0 wins the first tie.
  - An access in flight is abandoned. No ready is issued for it and no write strobe follows.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - px_req is sampled at each rising edge.
  - If exactly one port requests, it is granted.
  - If both request, the port ≠ last_grant is granted and last_grant is updated.
  - On grant, the winner's we, addr and wdata are latched into internal registers and the FSM moves to ACCESS with cnt=0.
  - No request: stay in IDLE.
- ACCESS:
  - mem_addr and mem_write_data are driven from the latched registers.
  - Write: mem_write=1 for exactly one cycle; the memory writes at the edge ending this cycle. Next state is DONE.
  - Read: mem_read=1 throughout. cnt increments each cycle. At the edge where cnt == WAIT_CYCLES-1, mem_read_data is captured into the rdata register and the FSM moves to DONE.
  - mem_read and mem_write are never high together.
- DONE:
  - mem_read=0, mem_write=0.
  - The granted port's ready = 1 for one cycle; its rdata holds the captured value (the last read value stays held for writes).
  - The other port's ready stays 0.
  - Next state is IDLE unconditionally.
- Latency, measured from the IDLE edge that grants to the ready cycle:
  - read: WAIT_CYCLES+1 cycles.
  - write: 2 cycles.
- Back-to-back: a requester that keeps req high after its ready is treated as issuing a new request in the following IDLE cycle. With both ports requesting continuously, grants alternate 0,1,0,1.
- Request-side inputs (we, addr, wdata) may change after the grant edge without effect until the next grant.
- Dropping a req before its ready does not cancel the access; ready still pulses.
- mem_addr and mem_write_data hold their last values in IDLE and DONE.
- grant is valid in ACCESS and DONE.

Decomposition:
- Shared package `mem_arb_pkg`:
  - state encoding constants: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
  - port index constants: PORT_CPU=0, PORT_DMA=1.
  - default WAIT_CYCLES.
- One sub-module: `rr_arb2`, a combinational two-way round-robin pick from req[1:0] and last_grant, returning a one-hot grant. The FSM, counter and datapath latches stay in the top module.

Test Plan:
- Reset held 3 cycles, then released with no requests -> all outputs 0, state IDLE, busy=0. Asserting reset mid-read -> mem_read drops without waiting for a clock edge; no ready pulse follows.
- Port 0 read of addr 0x10, memory word 4 = 0xDEADBEEF, WAIT_CYCLES=3 -> mem_read high exactly 3 cycles with mem_addr=0x10; p0_ready pulses on the 4th cycle after the grant edge with p0_rdata=0xDEADBEEF; p1_ready stays 0.
- Port 1 write of 0x12345678 to 0x40 -> mem_write high exactly 1 cycle; p1_ready pulses on the 2nd cycle; a subsequent port 0 read of 0x40 returns 0x12345678.
- Both ports request in the same cycle from reset -> port 0 granted first, then port 1. With both requests held continuously for 4 accesses, grant sequence is 01,10,01,10 and no cycle has mem_read and mem_write both high.
- WAIT_CYCLES=1 build, port 0 read of addr 0x0 with word 0 = 0xA5A5A5A5 -> p0_ready on the 2nd cycle with p0_rdata=0xA5A5A5A5. Port 1 changing p1_addr during its own ACCESS -> mem_addr stays at the latched value.
